// File: rtl/score_pkg.sv
// Shared constants and FSM encoding for the score keeper and its BCD/ASCII converter.
package score_pkg;

  localparam logic [7:0]  ASCII_ZERO = 8'h30;
  localparam logic [17:0] SCORE_MAX  = 18'd262143;
  localparam int          BIN_WIDTH  = 18;
  localparam int          BCD_DIGITS = 6;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PLAYING  = 2'd1,
    ST_DRAINING = 2'd2,
    ST_FINISHED = 2'd3
  } state_t;

endpackage

// File: rtl/bin2ascii_seq.sv
// Sequential double-dabble: binary -> 6 BCD digits -> ASCII; output loads 20 cycles after load.
// load is accepted at any time and restarts the engine; ascii only changes on a completed conversion.
module bin2ascii_seq
  import score_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [BIN_WIDTH-1:0]    bin,
  output logic                    busy,
  output logic [8*BCD_DIGITS-1:0] ascii
);

  logic [BIN_WIDTH-1:0]    shReg;
  logic [4*BCD_DIGITS-1:0] bcd;
  logic [4*BCD_DIGITS-1:0] bcdAdj;
  logic [8*BCD_DIGITS-1:0] asciiNext;
  logic [4:0]              shiftCnt;
  logic                    active;

  assign busy = active;

  always_comb begin
    bcdAdj = bcd;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) bcdAdj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
  end

  always_comb begin
    asciiNext = '0;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      asciiNext[8*d +: 8] = ASCII_ZERO | {4'h0, bcd[4*d +: 4]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shReg    <= '0;
      bcd      <= '0;
      shiftCnt <= '0;
      active   <= 1'b0;
      ascii    <= {BCD_DIGITS{ASCII_ZERO}};
    end else if (load) begin
      shReg    <= bin;
      bcd      <= '0;
      shiftCnt <= '0;
      active   <= 1'b1;
    end else if (active) begin
      // After the last shift the BCD register holds the full result; publish it in one go.
      if (shiftCnt == 5'(BIN_WIDTH)) begin
        ascii  <= asciiNext;
        active <= 1'b0;
      end else begin
        {bcd, shReg} <= {bcdAdj, shReg} << 1;
        shiftCnt     <= shiftCnt + 5'd1;
      end
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Song scoring: hit/miss -> score, streak, multiplier (latency 1); ASCII copy via bin2ascii_seq.
// No backpressure; done pulses once in DRAINING when the ASCII copy matches the final score.
module score_keeper
  import score_pkg::*;
#(
  parameter int BASE_POINTS = 10,
  parameter int STREAK_STEP = 10,
  parameter int MULT_MAX    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        hit,
  input  logic        miss,
  input  logic        song_end,
  output logic [17:0] binaryScore,
  output logic [47:0] asciiScore,
  output logic        done,
  output logic [2:0]  multiplier,
  output logic [7:0]  streak
);

  state_t      state, stateNext;
  logic        dirty;
  logic        convBusy;
  logic        convLoad;
  logic [17:0] convBin;
  logic [19:0] scoreSum;
  logic [17:0] scoreNext;
  logic [7:0]  streakInc, streakNext;
  logic [2:0]  multNew, multNext;
  int          multInt;

  assign scoreSum  = {2'b00, binaryScore} + (20'(BASE_POINTS) * {17'd0, multiplier});
  assign streakInc = (streak == 8'hFF) ? streak : streak + 8'd1;

  always_comb begin
    multInt = 1 + int'(streakInc) / STREAK_STEP;
    if (multInt > MULT_MAX) multInt = MULT_MAX;
    multNew = 3'(multInt);
  end

  always_comb begin
    scoreNext  = binaryScore;
    streakNext = streak;
    multNext   = multiplier;
    if (start) begin
      scoreNext  = '0;
      streakNext = '0;
      multNext   = 3'd1;
    end else if (state == ST_PLAYING) begin
      if (miss) begin
        streakNext = '0;
        multNext   = 3'd1;
      end else if (hit) begin
        scoreNext  = (scoreSum > {2'b00, SCORE_MAX}) ? SCORE_MAX : scoreSum[17:0];
        streakNext = streakInc;
        multNext   = multNew;
      end
    end
  end

  // start restarts the converter on zero so a stale in-flight result can never land.
  assign convLoad = start | (dirty & ~convBusy);
  assign convBin  = start ? '0 : binaryScore;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      binaryScore <= '0;
      streak      <= '0;
      multiplier  <= 3'd1;
      dirty       <= 1'b0;
    end else begin
      binaryScore <= scoreNext;
      streak      <= streakNext;
      multiplier  <= multNext;
      if (start)                         dirty <= 1'b0;
      else if (scoreNext != binaryScore) dirty <= 1'b1;
      else if (convLoad)                 dirty <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (start) begin
      stateNext = ST_PLAYING;
    end else begin
      case (state)
        ST_PLAYING:  if (song_end) stateNext = ST_DRAINING;
        ST_DRAINING: if (!convBusy && !dirty) stateNext = ST_FINISHED;
        default:     stateNext = state;
      endcase
    end
  end

  always_comb begin
    done = (state == ST_DRAINING) && !convBusy && !dirty && !start;
  end

  bin2ascii_seq u_bin2ascii (
    .clk   (clk),
    .reset (reset),
    .load  (convLoad),
    .bin   (convBin),
    .busy  (convBusy),
    .ascii (asciiScore)
  );

endmodule

// File: tb/tb_score_keeper.sv
// Randomized and directed bench for score_keeper against a plain-arithmetic scoring model.
module tb_score_keeper;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, hit, miss, song_end;
  logic [17:0] binaryScore;
  logic [47:0] asciiScore;
  logic        done;
  logic [2:0]  multiplier;
  logic [7:0]  streak;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int mScore, mStreak;
  bit playing, draining, doneSeen;

  always #5 clk = ~clk;

  score_keeper dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .hit         (hit),
    .miss        (miss),
    .song_end    (song_end),
    .binaryScore (binaryScore),
    .asciiScore  (asciiScore),
    .done        (done),
    .multiplier  (multiplier),
    .streak      (streak)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int multOf(input int s);
    int m;
    m = 1 + s / 10;
    return (m > 4) ? 4 : m;
  endfunction

  function automatic logic [47:0] toAscii(input int v);
    logic [47:0] r;
    int x;
    x = v;
    for (int d = 0; d < 6; d++) begin
      r[8*d +: 8] = 8'h30 + 8'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic void modelReset();
    mScore = 0; mStreak = 0; playing = 0; draining = 0; doneSeen = 0;
  endfunction

  // One clock with the given input pulses, then update model and compare.
  task automatic cycle(input bit h, input bit m, input bit se, input bit st);
    @(negedge clk);
    hit = h; miss = m; song_end = se; start = st;
    @(posedge clk);
    #1;
    hit = 0; miss = 0; song_end = 0; start = 0;
    if (st) begin
      mScore = 0; mStreak = 0; playing = 1; draining = 0; doneSeen = 0;
    end else if (playing) begin
      if (m) mStreak = 0;
      else if (h) begin
        mScore  = mScore + 10 * multOf(mStreak);
        if (mScore > 262143) mScore = 262143;
        mStreak = (mStreak == 255) ? 255 : mStreak + 1;
      end
      if (se) begin playing = 0; draining = 1; end
    end
    check("score", 64'(binaryScore), 64'(mScore));
    check("streak", 64'(streak), 64'(mStreak));
    check("mult", 64'(multiplier), 64'(multOf(mStreak)));
    if (done) begin
      check("done_allowed", 64'(draining && !doneSeen), 64'd1);
      check("done_ascii", 64'(asciiScore), 64'(toAscii(mScore)));
      doneSeen = 1;
    end
  endtask

  task automatic waitAscii(input string tag);
    for (int i = 0; i < 100 && asciiScore !== toAscii(mScore); i++) cycle(0, 0, 0, 0);
    check(tag, 64'(asciiScore), 64'(toAscii(mScore)));
  endtask

  initial begin
    reset = 0; start = 0; hit = 0; miss = 0; song_end = 0;
    modelReset();
    #12;
    check("rst_score", 64'(binaryScore), 64'd0);
    check("rst_ascii", 64'(asciiScore), 64'h303030303030);
    check("rst_done", 64'(done), 64'd0);
    check("rst_mult", 64'(multiplier), 64'd1);
    check("rst_streak", 64'(streak), 64'd0);
    @(negedge clk); reset = 1;

    // Ignored while idle
    cycle(1, 0, 0, 0);

    // Ten hits to x2, then one at x2
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0);
    check("ten_hits_score", 64'(binaryScore), 64'd100);
    check("ten_hits_mult", 64'(multiplier), 64'd2);
    cycle(1, 0, 0, 0);
    check("eleventh_score", 64'(binaryScore), 64'd120);
    waitAscii("ascii_120");
    check("ascii_120_lit", 64'(asciiScore), 64'h303030313230);

    // 35 hits, miss, hit
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 35; i++) cycle(1, 0, 0, 0);
    check("hits35_score", 64'(binaryScore), 64'd800);
    check("hits35_mult", 64'(multiplier), 64'd4);
    cycle(0, 1, 0, 0);
    check("miss_score", 64'(binaryScore), 64'd800);
    check("miss_mult", 64'(multiplier), 64'd1);
    cycle(1, 0, 0, 0);
    check("after_miss_score", 64'(binaryScore), 64'd810);
    check("after_miss_streak", 64'(streak), 64'd1);

    // hit + miss together counts as a miss
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 0);
    check("hitmiss_streak", 64'(streak), 64'd0);
    check("hitmiss_score", 64'(binaryScore), 64'd50);

    // Saturation
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 7000 && mScore < 262143; i++) cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("sat_score", 64'(binaryScore), 64'd262143);
    check("sat_streak", 64'(streak), 64'd255);
    waitAscii("ascii_sat");
    check("ascii_sat_lit", 64'(asciiScore), 64'h323632313433);

    // Asynchronous reset in the middle of a conversion
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
    @(negedge clk); #2 reset = 0; #1;
    modelReset();
    check("arst_score", 64'(binaryScore), 64'd0);
    check("arst_ascii", 64'(asciiScore), 64'h303030303030);
    check("arst_mult", 64'(multiplier), 64'd1);
    @(negedge clk); reset = 1;

    // hit, song_end two cycles later, done, ignored hit, restart
    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    for (int i = 0; i < 100 && !doneSeen; i++) cycle(0, 0, 0, 0);
    check("done_seen", 64'(doneSeen), 64'd1);
    cycle(0, 0, 0, 0);
    check("done_one_cycle", 64'(done), 64'd0);
    cycle(1, 0, 0, 0);
    check("post_done_hit_ignored", 64'(binaryScore), 64'd20);
    cycle(0, 0, 0, 1);
    check("restart_score", 64'(binaryScore), 64'd0);
    waitAscii("restart_ascii");
    cycle(1, 0, 0, 0);
    check("restart_playing", 64'(binaryScore), 64'd10);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bit h, m, se, st;
      h  = ($urandom % 3) == 0;
      m  = ($urandom % 12) == 0;
      se = ($urandom % 150) == 0;
      st = ($urandom % 400) == 0 || (!playing && ($urandom % 60) == 0);
      cycle(h, m, se, st);
    end
    waitAscii("final_ascii");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Scoring stage directly upstream of the song-select/high-score menu controller.
- Counts note hits and misses during a song and keeps a hit streak and a multiplier (x1..x4).
- Produces an 18-bit binary score and a 6-character zero-padded ASCII decimal copy for the display and high-score store.
- Pulses done once the song has ended and the ASCII copy matches the final binary score. The controller's done/binaryIn/asciiIn inputs are fed directly from this block.

Parameters:
- BASE_POINTS, 10: points per hit at x1.
- STREAK_STEP, 10: consecutive hits per multiplier step.
- MULT_MAX, 4: multiplier ceiling.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse from the menu controller's resetComp. Clears the score and begins a song.
- hit  in  1  one-cycle pulse: note played correctly.
- miss  in  1  one-cycle pulse: note missed.
- song_end  in  1  one-cycle pulse: song playback finished.
- binaryScore  out  18  current score. Feeds binaryIn.
- asciiScore  out  48  6 ASCII digits, MSD in [47:40]. Feeds asciiIn.
- done  out  1  one-cycle pulse: final score stable on both outputs.
- multiplier  out  3  current multiplier, 1..MULT_MAX.
- streak  out  8  consecutive-hit count.

Behaviour:
- Reset (reset=0, asynchronous) values:
  - binaryScore=0.
  - asciiScore={6{8'h30}}, i.e. "000000".
  - done=0, multiplier=1, streak=0.
  - Main FSM=IDLE, converter idle, dirty=0.
- Main FSM states: IDLE, PLAYING, DRAINING, FINISHED.
  - IDLE/FINISHED: hit, miss and song_end are ignored. start -> PLAYING.
  - PLAYING: hit/miss are scored. song_end -> DRAINING.
  - DRAINING: hit/miss are ignored. When the converter is idle and dirty=0, assert done for exactly one cycle and go to FINISHED.
- start (in any state, has the highest priority):
  - Next edge: binaryScore=0, streak=0, multiplier=1, done=0, state=PLAYING.
  - Forces an ASCII refresh to "000000"; any conversion in flight is aborted.
- Hit, with miss=0, in PLAYING:
  - binaryScore += BASE_POINTS*multiplier, using the multiplier in effect before this hit.
  - Saturate the score at 262143.
  - streak += 1, saturating at 255.
  - multiplier = min(1 + streak_new/STREAK_STEP, MULT_MAX).
  - All updates land on the edge after the pulse (latency 1).
- Miss, or hit and miss in the same cycle: treated as a miss. streak=0, multiplier=1, score unchanged.
- song_end in the same cycle as hit: the hit is scored, then the FSM enters DRAINING.
- Converter (sequential double-dabble, BCD->ASCII):
  - Any change to binaryScore sets dirty.
  - When the converter is idle and dirty=1, it snapshots binaryScore and clears dirty (1 cycle).
  - It then runs 18 shift/add-3 cycles on 6 BCD digits and loads asciiScore = 8'h30 | digit (1 cycle).
  - asciiScore updates exactly 20 cycles after the snapshot cycle.
  - A score change during a conversion sets dirty again. The current conversion finishes and its result loads; a new conversion then starts on the next cycle.
  - asciiScore never shows a partially converted value.
- done is never asserted while dirty=1 or while a conversion is in progress. On done, asciiScore is the decimal image of binaryScore.
- Reset asserted mid-song or mid-conversion: all state returns to reset values immediately.

Decomposition:
- Shared package score_pkg holds:
  - ASCII_ZERO=8'h30.
  - SCORE_MAX=18'd262143.
  - Main FSM state encodings (2-bit).
  - BCD digit count = 6.
- Natural sub-module: bin2ascii_seq.
  - Ports: clk, reset, load, bin[17:0], busy, ascii[47:0].
  - Contains the double-dabble engine and the ASCII output register.
- score_keeper holds the main FSM, the streak/multiplier logic and dirty tracking.

Test Plan:
- Reset, then observe outputs -> binaryScore=0, asciiScore=48'h303030303030, done=0, multiplier=1.
- start, then 10 hits, then 1 more hit -> score 100 after the 10th hit, multiplier=2, score 120 after the 11th hit. Once the converter is idle and dirty=0 (worst case a further ~40 cycles if a conversion was in flight at the 11th hit), asciiScore="000120".
- start, 35 hits, then 1 miss, then 1 hit:
  - Hits 1-10 score 10 each, 11-20 score 20, 21-30 score 30, 31-35 score 40 (x4 from streak 30).
  - Score = 100+200+300+200 = 800.
  - The miss leaves 800 and resets multiplier to 1; the final hit gives 810, streak=1.
- hit and miss in the same cycle with streak=5 -> streak=0, score unchanged.
- Score preloaded near the limit via repeated x4 hits until it exceeds 262143 -> binaryScore=262143, asciiScore="262143".
- hit then song_end 2 cycles later -> done pulses for 1 cycle, only after asciiScore updates. A later hit is ignored. A later start clears to 0, refreshes "000000", and returns to PLAYING.
